// File: rtl/schwap_bank_file_if.sv
// Register-file bus for schwap_bank_file: write/read ports, bank control and status.
// The master drives requests; the slave (the register file) returns read data and status.
interface schwap_bank_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2,
  parameter int BANK_W = 4
);
  logic              write;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] readAddrA;
  logic [ADDR_W-1:0] readAddrB;
  logic [DATA_W-1:0] readDataA;
  logic [DATA_W-1:0] readDataB;
  logic [BANK_W-1:0] bankSel;
  logic              bankLoad;
  logic              bankPush;
  logic              bankPop;
  logic              clearReq;
  logic [BANK_W-1:0] curBank;
  logic              busy;
  logic              stackFull;
  logic              stackEmpty;
  logic              err;

  modport master (
    output write, writeAddr, writeData, readAddrA, readAddrB,
    output bankSel, bankLoad, bankPush, bankPop, clearReq,
    input  readDataA, readDataB, curBank, busy, stackFull, stackEmpty, err
  );

  modport slave (
    input  write, writeAddr, writeData, readAddrA, readAddrB,
    input  bankSel, bankLoad, bankPush, bankPop, clearReq,
    output readDataA, readDataB, curBank, busy, stackFull, stackEmpty, err
  );
endinterface

// File: rtl/schwap_bank_file.sv
// Banked register file with bank stack and per-bank clear sequencer.
// Define SCHWAP_BYPASS_EN to forward same-cycle write data onto matching read ports.
module schwap_bank_file #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 2,
  parameter int BANK_W      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  schwap_bank_file_if.slave    bus
);

  localparam int REGS   = 2 ** ADDR_W;
  localparam int BANKS  = 2 ** BANK_W;
  localparam int SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int STK_IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int STK_N  = 2 ** STK_IW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic              busy;
  logic              clr_we;

  logic [BANK_W-1:0] cur_bank;
  logic [SP_W-1:0]   sp;
  logic [BANK_W-1:0] stack [STK_N];
  logic [DATA_W-1:0] mem [BANKS][REGS];

  logic              clr_acc;
  logic              pop_acc;
  logic              push_acc;
  logic              load_acc;
  logic              pop_ok;
  logic              push_ok;
  logic              err_nxt;
  logic              err_q;
  logic              stack_full;
  logic              stack_empty;

  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  // Bank-operation arbitration: one op per edge, clear > pop > push > load
  always_comb begin
    clr_acc  = !busy && bus.clearReq;
    pop_acc  = !busy && !bus.clearReq && bus.bankPop;
    push_acc = !busy && !bus.clearReq && !bus.bankPop && bus.bankPush;
    load_acc = !busy && !bus.clearReq && !bus.bankPop && !bus.bankPush && bus.bankLoad;
    pop_ok   = pop_acc && !stack_empty;
    push_ok  = push_acc && !stack_full;
    err_nxt  = (pop_acc && stack_empty) || (push_acc && stack_full);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_acc) state_nxt = CLEAR;
      CLEAR:   if (clr_idx == ADDR_W'(REGS - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == CLEAR);
    clr_we = (state == CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_idx <= '0;
    end else if (clr_acc) begin
      clr_idx <= '0;
    end else if (busy) begin
      clr_idx <= clr_idx + 1'b1;
    end
  end

  // Bank pointer, stack pointer and error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_bank <= '0;
      sp       <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_nxt;
      if (pop_ok) begin
        cur_bank <= stack[STK_IW'(sp - 1'b1)];
        sp       <= sp - 1'b1;
      end else if (push_ok) begin
        cur_bank <= bus.bankSel;
        sp       <= sp + 1'b1;
      end else if (load_acc) begin
        cur_bank <= bus.bankSel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack[STK_IW'(sp)] <= cur_bank;
    end
  end

  // Storage: clear sequencer owns the write port while busy; writes hit the pre-switch bank
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cur_bank][clr_idx] <= '0;
    end else if (bus.write) begin
      mem[cur_bank][bus.writeAddr] <= bus.writeData;
    end
  end

  always_comb begin
    bus.readDataA = mem[cur_bank][bus.readAddrA];
    bus.readDataB = mem[cur_bank][bus.readAddrB];
`ifdef SCHWAP_BYPASS_EN
    if (bus.write && !busy && (bus.readAddrA == bus.writeAddr)) bus.readDataA = bus.writeData;
    if (bus.write && !busy && (bus.readAddrB == bus.writeAddr)) bus.readDataB = bus.writeData;
`endif
  end

  assign bus.curBank    = cur_bank;
  assign bus.busy       = busy;
  assign bus.stackFull  = stack_full;
  assign bus.stackEmpty = stack_empty;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_schwap_bank_file.sv
// Bench for schwap_bank_file: directed scenarios plus random traffic, checked every cycle
// against an array/queue reference model of the banked register file.
module tb_schwap_bank_file;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;
  localparam int BANK_W = 4;
  localparam int DEPTH  = 4;
  localparam int REGS   = 2 ** ADDR_W;
  localparam int BANKS  = 2 ** BANK_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  schwap_bank_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus ();

  schwap_bank_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W), .STACK_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 0;

  // Reference model
  int m_mem [BANKS][REGS];
  bit m_vld [BANKS][REGS];
  int m_bank;
  int m_stk [$];
  int m_busy_left;
  int m_clr_idx;
  bit m_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bank = 0;
    m_stk.delete();
    m_busy_left = 0;
    m_clr_idx = 0;
    m_err = 0;
  endtask

  task automatic model_edge();
    bit nerr = 0;
    if (m_busy_left > 0) begin
      m_mem[m_bank][m_clr_idx] = 0;
      m_vld[m_bank][m_clr_idx] = 1;
      m_clr_idx++;
      m_busy_left--;
    end else begin
      if (bus.write) begin
        m_mem[m_bank][bus.writeAddr] = int'(bus.writeData);
        m_vld[m_bank][bus.writeAddr] = 1;
      end
      if (bus.clearReq) begin
        m_busy_left = REGS;
        m_clr_idx = 0;
      end else if (bus.bankPop) begin
        if (m_stk.size() > 0) m_bank = m_stk.pop_back();
        else nerr = 1;
      end else if (bus.bankPush) begin
        if (m_stk.size() < DEPTH) begin
          m_stk.push_back(m_bank);
          m_bank = int'(bus.bankSel);
        end else nerr = 1;
      end else if (bus.bankLoad) begin
        m_bank = int'(bus.bankSel);
      end
    end
    m_err = nerr;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.write = 0; bus.writeAddr = '0; bus.writeData = '0;
    bus.readAddrA = '0; bus.readAddrB = '0; bus.bankSel = '0;
    bus.bankLoad = 0; bus.bankPush = 0; bus.bankPop = 0; bus.clearReq = 0;
  endtask

  task automatic load_bank(input int b);
    bus.bankSel = BANK_W'(b); bus.bankLoad = 1; step(); bus.bankLoad = 0;
  endtask

  task automatic wr(input int a, input int d);
    bus.write = 1; bus.writeAddr = ADDR_W'(a); bus.writeData = DATA_W'(d); step(); bus.write = 0;
  endtask

  task automatic push(input int b);
    bus.bankSel = BANK_W'(b); bus.bankPush = 1; step(); bus.bankPush = 0;
  endtask

  task automatic pop();
    bus.bankPop = 1; step(); bus.bankPop = 0;
  endtask

  // Expected read value, honouring same-cycle forwarding in the bypass build
  task automatic exp_rd(input int a, output int val, output bit ok);
    val = m_mem[m_bank][a];
    ok  = m_vld[m_bank][a];
`ifdef SCHWAP_BYPASS_EN
    if (bus.write && m_busy_left == 0 && a == int'(bus.writeAddr)) begin
      val = int'(bus.writeData);
      ok  = 1;
    end
`endif
  endtask

  always @(negedge clk) begin
    int v;
    bit ok;
    if (chk_on && reset_n) begin
      check("curBank", 32'(bus.curBank), 32'(m_bank));
      check("busy", 32'(bus.busy), 32'(m_busy_left > 0));
      check("stackFull", 32'(bus.stackFull), 32'(m_stk.size() == DEPTH));
      check("stackEmpty", 32'(bus.stackEmpty), 32'(m_stk.size() == 0));
      check("err", 32'(bus.err), 32'(m_err));
      exp_rd(int'(bus.readAddrA), v, ok);
      if (ok) check("readDataA", 32'(bus.readDataA), 32'(v[DATA_W-1:0]));
      exp_rd(int'(bus.readAddrB), v, ok);
      if (ok) check("readDataB", 32'(bus.readDataB), 32'(v[DATA_W-1:0]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    idle_inputs();
    model_reset();
    step(); step();
    check("rst_curBank", 32'(bus.curBank), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_stackEmpty", 32'(bus.stackEmpty), 32'd1);
    check("rst_stackFull", 32'(bus.stackFull), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset_n = 1;
    chk_on = 1;

    // Fill every bank with b*4+r, then read back through both ports
    for (int b = 0; b < BANKS; b++) begin
      load_bank(b);
      for (int r = 0; r < REGS; r++) wr(r, b * 4 + r);
    end
    for (int b = 0; b < BANKS; b++) begin
      load_bank(b);
      for (int r = 0; r < REGS; r++) begin
        bus.readAddrA = ADDR_W'(r);
        bus.readAddrB = ADDR_W'(REGS - 1 - r);
        #1;
        check("fill_rdA", 32'(bus.readDataA), 32'(b * 4 + r));
        check("fill_rdB", 32'(bus.readDataB), 32'(b * 4 + REGS - 1 - r));
      end
    end

    // Stack push/pop sequence with overflow and underflow
    load_bank(0);
    push(3); push(5); push(7); push(9);
    check("push_cur9", 32'(bus.curBank), 32'd9);
    check("push_full", 32'(bus.stackFull), 32'd1);
    push(2);
    check("ovf_err", 32'(bus.err), 32'd1);
    check("ovf_cur", 32'(bus.curBank), 32'd9);
    step();
    check("ovf_err_low", 32'(bus.err), 32'd0);
    pop(); check("pop1", 32'(bus.curBank), 32'd7);
    pop(); check("pop2", 32'(bus.curBank), 32'd5);
    pop(); check("pop3", 32'(bus.curBank), 32'd3);
    pop(); check("pop4", 32'(bus.curBank), 32'd0);
    pop();
    check("udf_err", 32'(bus.err), 32'd1);
    check("udf_cur", 32'(bus.curBank), 32'd0);
    check("udf_empty", 32'(bus.stackEmpty), 32'd1);
    step();
    check("udf_err_low", 32'(bus.err), 32'd0);

    // Clear bank 6; a write during busy must be dropped
    load_bank(6);
    for (int r = 0; r < REGS; r++) wr(r, 16'hFFFF);
    bus.clearReq = 1; step(); bus.clearReq = 0;
    cnt = 0;
    while (bus.busy && cnt < 20) begin
      cnt++;
      if (cnt == 2) begin
        bus.write = 1; bus.writeAddr = '0; bus.writeData = 16'hBEEF;
        step();
        bus.write = 0;
      end else step();
    end
    check("clr_busy_cycles", 32'(cnt), 32'd4);
    for (int r = 0; r < REGS; r++) begin
      bus.readAddrA = ADDR_W'(r); #1;
      check("clr_bank6_zero", 32'(bus.readDataA), 32'd0);
    end
    load_bank(5);
    for (int r = 0; r < REGS; r++) begin
      bus.readAddrA = ADDR_W'(r); #1;
      check("clr_bank5_kept", 32'(bus.readDataA), 32'(5 * 4 + r));
    end

    // Reset aborts a clear after two registers are zeroed
    load_bank(6);
    for (int r = 0; r < REGS; r++) wr(r, 16'hFFFF);
    bus.clearReq = 1; step(); bus.clearReq = 0;
    step(); step();
    reset_n = 0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_cur", 32'(bus.curBank), 32'd0);
    model_reset();
    step();
    reset_n = 1;
    load_bank(6);
    for (int r = 0; r < REGS; r++) begin
      bus.readAddrA = ADDR_W'(r); #1;
      check("abort_bank6", 32'(bus.readDataA), (r < 2) ? 32'd0 : 32'hFFFF);
    end

    // Write-then-read in the same cycle
    load_bank(1);
    wr(2, 16'h1234);
    bus.write = 1; bus.writeAddr = 2; bus.writeData = 16'hA5A5; bus.readAddrA = 2;
    #1;
`ifdef SCHWAP_BYPASS_EN
    check("byp_pre", 32'(bus.readDataA), 32'hA5A5);
`else
    check("byp_pre", 32'(bus.readDataA), 32'h1234);
`endif
    step();
    bus.write = 0;
    check("byp_post", 32'(bus.readDataA), 32'hA5A5);

    // Pop wins over push and load
    push(4);
    bus.bankPop = 1; bus.bankPush = 1; bus.bankLoad = 1; bus.bankSel = 8;
    step();
    idle_inputs();
    check("prio_empty", 32'(bus.stackEmpty), 32'd1);
    check("prio_cur", 32'(bus.curBank), 32'd1);

    // Random traffic checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      bus.write     = ($urandom_range(0, 1) == 1);
      bus.writeAddr = ADDR_W'($urandom);
      bus.writeData = DATA_W'($urandom);
      bus.readAddrA = ADDR_W'($urandom);
      bus.readAddrB = ($urandom_range(0, 3) == 0) ? bus.writeAddr : ADDR_W'($urandom);
      bus.bankSel   = BANK_W'($urandom);
      bus.bankLoad  = ($urandom_range(0, 3) == 0);
      bus.bankPush  = ($urandom_range(0, 4) == 0);
      bus.bankPop   = ($urandom_range(0, 4) == 0);
      bus.clearReq  = ($urandom_range(0, 24) == 0);
      #3;
      step();
    end
    idle_inputs();
    step();

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/schwap_bank_file.md
# schwap_bank_file

Parametrised banked register file: the successor to the fixed 16×4×16-bit schwap block. It provides BANKS banks of REGS registers, two combinational read ports and one write port, all on a single clock. Bank selection is synchronous, with a direct-load path and a hardware bank stack for call/return context switching. A per-bank clear sequencer is also included. It sits between the decode stage and the ALU operand muxes in the CPU datapath.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 2, register address width; REGS = 2**ADDR_W registers per bank
- BANK_W, 4, bank index width; BANKS = 2**BANK_W
- STACK_DEPTH, 4, bank-stack entries (≥1)
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- write  in  1  write enable for the current bank
- writeAddr  in  ADDR_W  write register index
- writeData  in  DATA_W  write data
- readAddrA, readAddrB  in  ADDR_W  read indices
- readDataA, readDataB  out  DATA_W  combinational read data from the current bank
- bankSel  in  BANK_W  target bank for load/push
- bankLoad  in  1  set the current bank to bankSel
- bankPush  in  1  push the current bank, then switch to bankSel
- bankPop  in  1  restore the current bank from the stack top
- clearReq  in  1  zero every register of the current bank
- curBank  out  BANK_W  current bank index
- busy  out  1  clear sequence in progress
- stackFull, stackEmpty  out  1  bank-stack status
- err  out  1  one-cycle pulse on push-when-full or pop-when-empty

## Operation
- Reset values:
  - curBank=0, stack pointer sp=0, stackEmpty=1, stackFull=0, busy=0, err=0, FSM=IDLE.
  - Register contents are not reset.
- Reads: readDataX = mem[curBank][readAddrX], combinational.
- Writes: on a rising edge with write=1 and busy=0, mem[curBank][writeAddr] ← writeData.
- Bank operations:
  - Evaluated only when busy=0. At most one is accepted per edge, with priority clearReq > bankPop > bankPush > bankLoad.
  - A write in the same cycle as a bank operation targets the old curBank.
- bankLoad: curBank ← bankSel.
- bankPush:
  - If sp<STACK_DEPTH: stack[sp] ← curBank, sp ← sp+1, curBank ← bankSel.
  - Otherwise: no state change, err=1 for one cycle.
- bankPop:
  - If sp>0: curBank ← stack[sp-1], sp ← sp-1.
  - Otherwise: no change, err=1 for one cycle.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE→CLEAR on an accepted clearReq; the index counter is loaded with 0.
  - In CLEAR, each edge writes 0 to mem[curBank][idx] and increments idx.
  - After the write to idx=REGS-1 the FSM returns to IDLE.
- While busy:
  - write, bankLoad, bankPush, bankPop and clearReq are ignored, with no err.
  - Reads return current (partially cleared) contents.
- Asynchronous reset mid-clear aborts to IDLE. Registers already zeroed stay zero; the rest keep their old values.
- stackFull = (sp==STACK_DEPTH), stackEmpty = (sp==0), both combinational from sp.

## Timing
- Read latency: 0 cycles (combinational).
- Write result is visible on the read ports immediately after the capturing edge.
- Bank change is visible on curBank and the read ports after the accepting edge.
- Clear accepted at edge k:
  - busy=1 from after edge k until after edge k+REGS, i.e. exactly REGS cycles.
  - Register i is zeroed at edge k+1+i.
- err goes high after the offending edge and low after the next edge.

## Configuration
- SCHWAP_BYPASS_EN defined:
  - If write=1, busy=0 and readAddrX==writeAddr, readDataX = writeData combinationally in the same cycle.
  - Write-then-read in one cycle returns the new data.
- SCHWAP_BYPASS_EN undefined: read ports always return the stored value; the new value appears after the edge.

## Test plan
- Default parameters. For every bank b, load b and write value b*4+r to each register r. Then load each bank and read back on both ports → every read equals b*4+r; no cross-bank aliasing.
- Push banks 3, 5, 7, 9 from bank 0, then push 2 → err pulses for 1 cycle, curBank stays 9, stackFull=1. Then pop ×4 → curBank 7, 5, 3, 0. A fifth pop → err pulse, curBank=0, stackEmpty=1.
- Bank 6 holds 0xFFFF in all registers; clearReq → busy high exactly 4 cycles. A write issued during busy is ignored. Afterwards bank 6 reads 0 and bank 5 is untouched.
- clearReq, then reset_n low after 2 cycles → busy=0 and curBank=0 immediately. Bank 6 regs 0–1 read 0, regs 2–3 read 0xFFFF.
- write=1, writeAddr=readAddrA=2, writeData=0xA5A5 over old value 0x1234 → readDataA=0xA5A5 pre-edge with SCHWAP_BYPASS_EN, 0x1234 pre-edge without. Both builds read 0xA5A5 post-edge.
- Same cycle: bankPop, bankPush and bankLoad all asserted with sp=1 → only the pop takes effect and sp=0.
